reg_wb_arbiter: RTL and testbench
=================================

// Module: reg_wb_arbiter
// PURPOSE
// - Shares the register file's single write port (W_en/W_reg/W_data) between N_SRC writeback sources (ALU, load unit).
// - Each source has a valid/ready queue; a round-robin arbiter drains one entry per cycle into the port.
// - Maintains a per-register pending-write mask so issue logic can stall on RAW hazards.
// - Sits between the execute/memory stages and the register file.
// PARAMETERS
// - N_SRC       2   number of writeback sources
// - FIFO_DEPTH  2   entries per source queue (power of 2, >=2)
// - ADDR_W      5   register index width
// - DATA_W      32  write data width
// PORTS
// - clk        in   1               single clock, rising edge
// - reset      in   1               reset is synchronous and active-high
// - src_valid  in   N_SRC           source i presents a write
// - src_ready  out  N_SRC           source i queue accepts this cycle
// - src_reg    in   N_SRC*ADDR_W    destination register, source i at [i*ADDR_W +: ADDR_W]
// - src_data   in   N_SRC*DATA_W    write data, source i at [i*DATA_W +: DATA_W]
// - W_en       out  1               register file write enable
// - W_reg      out  ADDR_W          register file write index
// - W_data     out  DATA_W          register file write data
// - pend_mask  out  32              bit r = 1 while a queued write targets register r
// - idle       out  1               all queues empty
// BEHAVIOUR
// - Accept: src_valid[i] && src_ready[i] at a rising edge enqueues {src_reg, src_data} into queue i.
// - src_ready[i] = !full[i] && !conflict[i]. conflict[i] = src_reg[i] != 0 and, for a j != i,
//   either pend_cnt[src_reg[i]] counts entries queued by source j, or src_valid[j] && src_ready[j]
//   for the same register with j < i. Result: same-register writes from different sources never coexist.
// - Register 0: handshake completes normally; entry is discarded, never queued, never written.
// - Arbitration: combinational over non-empty queues, round-robin starting at rr_ptr; winner head drives
//   W_en=1, W_reg, W_data in the same cycle. Head popped at that edge; rr_ptr <= winner+1 (mod N_SRC).
//   No winner: W_en=0, W_reg=0, W_data=0.
// - Latency: handshake at edge c -> W_en high in cycle c+1 when uncontended. Throughput: one write per cycle total.
// - Order: FIFO order per source. No cross-source order; conflict rule makes it unnecessary.
// - pend_cnt[r]: width $clog2(N_SRC*FIFO_DEPTH+1). +1 on enqueue to r, -1 on pop to r. Same-edge enqueue and pop
//   to r leave it unchanged. pend_mask[r] = (pend_cnt[r] != 0); bit 0 always 0.
// - Full queue: src_ready low, no overwrite. Popped and written in the same cycle: ready reflects
//   pre-pop occupancy (no bypass).
// - Empty queue: head ignored by arbiter. Pointers wrap modulo FIFO_DEPTH.
// - idle = all queues empty (combinational).
// - Reset (any cycle, mid-burst included): W_en, src_ready and pend_mask forced to 0 combinationally while reset=1.
//   At the edge: queues flushed, pend_cnt cleared, rr_ptr=0. In-flight entries are lost. idle=1 from the next cycle.
// STRUCTURE
// - Package reg_wb_pkg: ADDR_W, DATA_W, N_REGS=32, source IDs SRC_ALU=0 and SRC_LOAD=1, wb_entry_t {reg, data}.
// - Sub-module wb_fifo: synchronous FIFO (push, pop, full, empty, head), instantiated N_SRC times.
// - Top level holds the rr arbiter, conflict logic and pend_cnt array.
// TESTING
// - Reset, then single ALU write r5=0x12345678 at cycle c:
//   W_en=1, W_reg=5, W_data=0x12345678 in c+1; pend_mask[5]=1 in c+1, 0 in c+2.
// - Both sources valid every cycle, distinct registers (ALU r1..r4, LOAD r9..r12):
//   W_reg alternates 1,9,2,10,...; one write per cycle; no loss.
// - Hold ALU stalled-free with LOAD idle, 3 back-to-back pushes:
//   src_ready never drops below one write per cycle; FIFO order r1,r2,r3 preserved.
// - ALU queues r7; LOAD presents r7 the next cycle:
//   src_ready[1]=0 until ALU r7 is written; then accepted; final write order ALU then LOAD.
// - Same-cycle ALU r3 and LOAD r3 with empty queues: only ALU accepted; LOAD ready=0 that cycle.
// - Write to r0 -> accepted, W_en stays 0, pend_mask=0. Reset asserted with 3 entries queued ->
//   W_en=0 during reset, idle=1 and pend_mask=0 the cycle after reset.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// reg_wb_pkg: shared constants and types for the register writeback arbiter.
//   ADDR_W / DATA_W : default register index and write data widths
//   N_REGS          : architectural register count; also the pend_mask width
//   SRC_ALU/SRC_LOAD: writeback source IDs, i.e. bit positions in src_valid/src_ready
//   wb_entry_t      : one queued write {reg_idx, data} at the default widths
package reg_wb_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int N_REGS   = 32;
  localparam int SRC_ALU  = 0;
  localparam int SRC_LOAD = 1;

  // The field is called reg_idx because "reg" is a keyword.
  typedef struct packed {
    logic [ADDR_W-1:0] reg_idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// wb_fifo: synchronous FIFO that holds one writeback source's queued writes.
//   clk, reset : rising-edge clock, synchronous active-high reset (empties the queue)
//   push, din  : enqueue din; ignored while full
//   pop        : drop the head entry; ignored while empty
//   full/empty : occupancy flags for the current cycle, before any push or pop
//   head       : oldest entry; only meaningful while !empty
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == '0);
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array. It has no reset because the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: N_SRC writeback sources share the register file's single write port.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   src_valid/ready   : per-source handshake; a write is accepted when both are high
//   src_reg/src_data  : packed per source (source i at [i*W +: W])
//   W_en/W_reg/W_data : register file write port, driven the same cycle as the arbitration
//   pend_mask         : bit r is set while any queued write targets register r
//   idle              : every source queue is empty
// Each source has its own queue, and a round-robin arbiter drains one head per cycle.
// Two sources may never have writes to the same register queued at the same time.
// This rule removes the need for any ordering between sources.
module reg_wb_arbiter #(
  parameter int N_SRC      = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = reg_wb_pkg::ADDR_W,
  parameter int DATA_W     = reg_wb_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        src_valid,
  output logic [N_SRC-1:0]        src_ready,
  input  logic [N_SRC*ADDR_W-1:0] src_reg,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic                    W_en,
  output logic [ADDR_W-1:0]       W_reg,
  output logic [DATA_W-1:0]       W_data,
  output logic [31:0]             pend_mask,
  output logic                    idle
);

  import reg_wb_pkg::*;

  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CW = $clog2(N_SRC * FIFO_DEPTH + 1);
  localparam int EW = ADDR_W + DATA_W;

  logic [N_SRC-1:0]  full_s;
  logic [N_SRC-1:0]  empty_s;
  logic [N_SRC-1:0]  push_s;
  logic [N_SRC-1:0]  pop_s;
  logic [N_SRC-1:0]  accept_s;
  logic [N_SRC-1:0]  conflict_s;
  logic [EW-1:0]     head_s [N_SRC];
  logic [ADDR_W-1:0] reg_s  [N_SRC];
  logic              hit_s;

  logic [CW-1:0]     pend_cnt_r [N_REGS];
  logic [SW-1:0]     owner_r    [N_REGS];  // source that owns a register while its pend_cnt != 0
  logic [N_REGS-1:0] inc_s;
  logic [N_REGS-1:0] dec_s;

  logic [SW-1:0]     rr_ptr_r;
  logic [SW:0]       sum_s;
  logic [SW-1:0]     idx_s;
  logic [SW-1:0]     win_s;
  logic              win_vld_s;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign reg_s[i] = src_reg[i*ADDR_W +: ADDR_W];

    wb_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s[i]),
      .pop   (pop_s[i]),
      .din   ({reg_s[i], src_data[i*DATA_W +: DATA_W]}),
      .full  (full_s[i]),
      .empty (empty_s[i]),
      .head  (head_s[i])
    );
  end

  assign idle = &empty_s;

  // Ready and accept, resolved in ascending source order.
  // A lower-index source that accepts a register this cycle blocks higher-index sources for that register.
  // Register 0 writes complete the handshake but are never pushed.
  always_comb begin
    conflict_s = '0;
    src_ready  = '0;
    accept_s   = '0;
    push_s     = '0;
    hit_s      = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      hit_s = (pend_cnt_r[reg_s[i]] != '0) && (owner_r[reg_s[i]] != SW'(i));
      for (int j = 0; j < i; j++) begin
        hit_s = hit_s || (accept_s[j] && (reg_s[j] == reg_s[i]));
      end
      conflict_s[i] = hit_s && (reg_s[i] != '0);
      src_ready[i]  = !reset && !full_s[i] && !conflict_s[i];
      accept_s[i]   = src_valid[i] && src_ready[i];
      push_s[i]     = accept_s[i] && (reg_s[i] != '0);
    end
  end

  // Round-robin search: take the first non-empty queue at or after rr_ptr_r.
  always_comb begin
    win_vld_s = 1'b0;
    win_s     = '0;
    sum_s     = '0;
    idx_s     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      sum_s = {1'b0, rr_ptr_r} + (SW+1)'(k);
      if (sum_s >= (SW+1)'(N_SRC)) begin
        sum_s = sum_s - (SW+1)'(N_SRC);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[SW-1:0];
      if (!win_vld_s && !empty_s[idx_s]) begin
        win_vld_s = 1'b1;
        win_s     = idx_s;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  // Write port driven from the winning head. The head is popped at the same edge.
  always_comb begin
    W_en  = win_vld_s && !reset;
    pop_s = '0;
    pop_s[win_s] = W_en;
    if (W_en) begin
      W_reg  = head_s[win_s][EW-1 -: ADDR_W];
      W_data = head_s[win_s][DATA_W-1:0];
    end else begin
      W_reg  = '0;
      W_data = '0;
    end
  end

  // Per-register increment and decrement strobes. The conflict rule allows at most one push per register per cycle.
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (push_s[i]) begin
        inc_s[reg_s[i]] = 1'b1;
      end else begin
        inc_s = inc_s;
      end
    end
    if (W_en) begin
      dec_s[W_reg] = 1'b1;
    end else begin
      dec_s = dec_s;
    end
  end

  // Pending mask. Register 0 is never queued, and the mask is held at 0 during reset.
  always_comb begin
    pend_mask = 32'd0;
    for (int r = 1; r < N_REGS; r++) begin
      pend_mask[r] = !reset && (pend_cnt_r[r] != '0);
    end
  end

  // Round-robin pointer, pending counters and register ownership.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r <= '0;
      for (int r = 0; r < N_REGS; r++) begin
        pend_cnt_r[r] <= '0;
        owner_r[r]    <= '0;
      end
    end else begin
      if (W_en) begin
        rr_ptr_r <= (win_s == SW'(N_SRC - 1)) ? '0 : win_s + SW'(1);
      end
      for (int r = 0; r < N_REGS; r++) begin
        case ({inc_s[r], dec_s[r]})
          2'b10:   pend_cnt_r[r] <= pend_cnt_r[r] + CW'(1);
          2'b01:   pend_cnt_r[r] <= pend_cnt_r[r] - CW'(1);
          default: pend_cnt_r[r] <= pend_cnt_r[r];
        endcase
      end
      for (int i = 0; i < N_SRC; i++) begin
        if (push_s[i]) begin
          owner_r[reg_s[i]] <= SW'(i);
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed bench for reg_wb_arbiter (N_SRC=2, FIFO_DEPTH=2).
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on the falling edge.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  src_valid;
  logic [1:0]  src_ready;
  logic [9:0]  src_reg;
  logic [63:0] src_data;
  logic        W_en;
  logic [4:0]  W_reg;
  logic [31:0] W_data;
  logic [31:0] pend_mask;
  logic        idle;

  int n_tests = 0;
  int n_fail  = 0;
  int ai, li, oi, first_c, last_c;
  logic [4:0] exp_b [8];

  always #5 clk = ~clk;

  reg_wb_arbiter #(
    .N_SRC      (2),
    .FIFO_DEPTH (2),
    .ADDR_W     (5),
    .DATA_W     (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_reg   (src_reg),
    .src_data  (src_data),
    .W_en      (W_en),
    .W_reg     (W_reg),
    .W_data    (W_data),
    .pend_mask (pend_mask),
    .idle      (idle)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic va, input logic [4:0] ra, input logic [31:0] da,
                       input logic vl, input logic [4:0] rl, input logic [31:0] dl);
    src_valid = {vl, va};
    src_reg   = {rl, ra};
    src_data  = {dl, da};
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    to_drive();
    to_drive();
    reset = 1'b0;
  endtask

  initial begin
    exp_b = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    to_drive();
    to_drive();

    // Reset state
    to_sample();
    check("rst_w_en",  {31'd0, W_en}, 32'd0);
    check("rst_ready", {30'd0, src_ready}, 32'd0);
    check("rst_pend",  pend_mask, 32'd0);
    to_drive();
    reset = 1'b0;
    to_sample();
    check("rst_idle",  {31'd0, idle}, 32'd1);
    check("rst_ready_after", {30'd0, src_ready}, 32'd3);

    // Single ALU write r5
    to_drive();
    drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    to_sample();
    check("a_ready", {31'd0, src_ready[0]}, 32'd1);
    check("a_w_en_c", {31'd0, W_en}, 32'd0);
    to_drive();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    to_sample();
    check("a_w_en",  {31'd0, W_en}, 32'd1);
    check("a_w_reg", {27'd0, W_reg}, 32'd5);
    check("a_w_data", W_data, 32'h1234_5678);
    check("a_pend_set", pend_mask, 32'h0000_0020);
    to_drive();
    to_sample();
    check("a_w_en_after", {31'd0, W_en}, 32'd0);
    check("a_pend_clr", pend_mask, 32'd0);
    check("a_idle", {31'd0, idle}, 32'd1);

    // Both sources stream distinct registers, starting from rr_ptr = 0
    do_reset();
    ai = 0; li = 0; oi = 0; first_c = -1; last_c = -1;
    for (int cyc = 0; cyc < 40 && oi < 8; cyc++) begin
      to_drive();
      drive(ai < 4, 5'(1 + ai), 32'hA000_0000 + 32'(1 + ai),
            li < 4, 5'(9 + li), 32'hB000_0000 + 32'(9 + li));
      to_sample();
      if (W_en) begin
        check("b_w_reg", {27'd0, W_reg}, {27'd0, exp_b[oi]});
        check("b_w_data", W_data,
              ((exp_b[oi] < 5'd9) ? 32'hA000_0000 : 32'hB000_0000) + {27'd0, exp_b[oi]});
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        oi++;
      end
      if (src_valid[0] && src_ready[0]) ai++;
      if (src_valid[1] && src_ready[1]) li++;
    end
    check("b_writes", oi, 32'd8);
    check("b_span", last_c - first_c, 32'd7);

    // ALU alone, three back-to-back pushes
    ai = 0; oi = 0; first_c = -1; last_c = -1;
    for (int cyc = 0; cyc < 20 && oi < 3; cyc++) begin
      to_drive();
      drive(ai < 3, 5'(1 + ai), 32'hC000_0000 + 32'(1 + ai), 1'b0, 5'd0, 32'd0);
      to_sample();
      if (ai < 3) check("c_ready", {31'd0, src_ready[0]}, 32'd1);
      if (W_en) begin
        check("c_w_reg", {27'd0, W_reg}, 32'(oi + 1));
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        oi++;
      end
      if (src_valid[0] && src_ready[0]) ai++;
    end
    check("c_writes", oi, 32'd3);
    check("c_span", last_c - first_c, 32'd2);

    // ALU queues r7, and LOAD presents r7 one cycle later
    to_drive();
    drive(1'b1, 5'd7, 32'h0000_7A7A, 1'b0, 5'd0, 32'd0);
    to_sample();
    check("d_alu_ready", {31'd0, src_ready[0]}, 32'd1);
    to_drive();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_7B7B);
    to_sample();
    check("d_load_blocked", {31'd0, src_ready[1]}, 32'd0);
    check("d_w_reg", {27'd0, W_reg}, 32'd7);
    check("d_w_data_alu", W_data, 32'h0000_7A7A);
    to_drive();
    to_sample();
    check("d_load_ready", {31'd0, src_ready[1]}, 32'd1);
    check("d_w_en_gap", {31'd0, W_en}, 32'd0);
    to_drive();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    to_sample();
    check("d_w_en_load", {31'd0, W_en}, 32'd1);
    check("d_w_data_load", W_data, 32'h0000_7B7B);

    // Same-cycle r3 from both sources into empty queues
    to_drive();
    drive(1'b1, 5'd3, 32'h0000_3A3A, 1'b1, 5'd3, 32'h0000_3B3B);
    to_sample();
    check("e_ready", {30'd0, src_ready}, 32'd1);
    to_drive();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_3B3B);
    to_sample();
    check("e_w_data_alu", W_data, 32'h0000_3A3A);
    check("e_load_blocked", {31'd0, src_ready[1]}, 32'd0);
    to_drive();
    to_sample();
    check("e_load_ready", {31'd0, src_ready[1]}, 32'd1);
    to_drive();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    to_sample();
    check("e_w_data_load", W_data, 32'h0000_3B3B);

    // Write to r0 is accepted and discarded
    to_drive();
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    to_sample();
    check("f_ready", {31'd0, src_ready[0]}, 32'd1);
    to_drive();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    to_sample();
    check("f_w_en", {31'd0, W_en}, 32'd0);
    check("f_pend", pend_mask, 32'd0);
    check("f_idle", {31'd0, idle}, 32'd1);

    // Reset with three entries queued
    to_drive();
    drive(1'b1, 5'd1, 32'h0000_0001, 1'b1, 5'd9, 32'h0000_0009);
    to_sample();
    to_drive();
    drive(1'b1, 5'd2, 32'h0000_0002, 1'b1, 5'd10, 32'h0000_000A);
    to_sample();
    check("g_ready", {30'd0, src_ready}, 32'd3);
    to_drive();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    to_sample();
    check("g_rst_w_en", {31'd0, W_en}, 32'd0);
    check("g_rst_ready", {30'd0, src_ready}, 32'd0);
    check("g_rst_pend", pend_mask, 32'd0);
    check("g_rst_busy", {31'd0, idle}, 32'd0);
    to_drive();
    reset = 1'b0;
    to_sample();
    check("g_idle", {31'd0, idle}, 32'd1);
    check("g_pend", pend_mask, 32'd0);
    check("g_w_en", {31'd0, W_en}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
